// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, exception flags and integer/exponent limits.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rm_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam logic [31:0] INT_MAX_S = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN_S = 32'h8000_0000;
    localparam logic [31:0] INT_MAX_U = 32'hFFFF_FFFF;
    localparam int          FLT_EXP_BIAS = 127;

    // |x| >= 2^32 from this exponent up; below the tiny limit |x| < 2^-3 and the shifter output is unusable
    localparam logic [7:0] EXP_BIG_MIN  = 8'(FLT_EXP_BIAS + 32);
    localparam logic [7:0] EXP_TINY_LIM = 8'(FLT_EXP_BIAS - 3);

endpackage

// File: rtl/fpu_f2i_round_if.sv
// Valid/ready handshake bundle between the float-to-fixed shifter, the rounding stage and FP writeback.
interface fpu_f2i_round_if #(
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_flt;
    logic [34:0]      in_fixed;
    logic             in_is_signed;
    logic [2:0]       in_rm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [4:0]       out_fflags;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_flt, in_fixed, in_is_signed, in_rm, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_fflags, out_tag
    );

    modport slave (
        input  in_valid, in_flt, in_fixed, in_is_signed, in_rm, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_fflags, out_tag
    );
endinterface

// File: rtl/fpu_round_incr.sv
// Round-increment decision from sign, rounding mode, lsb, guard and sticky-or-round bits.
module fpu_round_incr
    import fpu_pkg::*;
(
    input  logic       sign,
    input  logic [2:0] rm,
    input  logic       lsb,
    input  logic       g,
    input  logic       x,
    output logic       inc
);

    // Unused encodings fall through to truncation; they never reach here from decode
    always_comb begin
        inc = 1'b0;
        case (rm)
            RNE:     inc = g & (x | lsb);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (g | x);
            RUP:     inc = ~sign & (g | x);
            RMM:     inc = g;
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_f2i_round.sv
// Float-to-integer rounding, saturation and exception stage; two-stage valid/ready pipeline.
module fpu_f2i_round
    import fpu_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    fpu_f2i_round_if.slave  bus
);

    logic [7:0]  f_exp;
    logic        c_sign, c_nan, c_big, c_zero, c_tiny;
    logic [31:0] c_int;
    logic        c_g, c_x, c_inc;
    logic [32:0] c_mag;

    logic             s1_valid, s1_nan, s1_big, s1_sign, s1_signed, s1_inexact;
    logic [32:0]      s1_mag;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid, s2_adv;
    logic [31:0]      s2_result;
    fflags_t          s2_flags;
    logic [TAG_W-1:0] s2_tag;

    logic        ovf;
    logic [31:0] sat, r_result;
    fflags_t     r_flags;

    assign f_exp = bus.in_flt[30:23];

    // Zero and tiny operands bypass the shifter magnitude
    always_comb begin
        c_sign = bus.in_flt[31];
        c_nan  = (f_exp == 8'hFF) && (bus.in_flt[22:0] != '0);
        c_big  = (f_exp >= EXP_BIG_MIN);
        c_zero = (bus.in_flt[30:0] == '0);
        c_tiny = (f_exp < EXP_TINY_LIM) && !c_zero;
        c_int  = bus.in_fixed[34:3];
        c_g    = bus.in_fixed[2];
        c_x    = bus.in_fixed[1] | bus.in_fixed[0];
        if (c_zero) begin
            c_int = '0;
            c_g   = 1'b0;
            c_x   = 1'b0;
        end else if (c_tiny) begin
            c_int = '0;
            c_g   = 1'b0;
            c_x   = 1'b1;
        end
    end

    fpu_round_incr u_round_incr (
        .sign (c_sign),
        .rm   (bus.in_rm),
        .lsb  (c_int[0]),
        .g    (c_g),
        .x    (c_x),
        .inc  (c_inc)
    );

    assign c_mag = {1'b0, c_int} + 33'(c_inc);

    assign s2_adv       = ~s2_valid | bus.out_ready;
    assign bus.in_ready = ~s1_valid | s2_adv;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            s1_valid <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
        end
        if (bus.in_valid && bus.in_ready) begin
            s1_nan     <= c_nan;
            s1_big     <= c_big;
            s1_sign    <= c_sign;
            s1_signed  <= bus.in_is_signed;
            s1_mag     <= c_mag;
            s1_inexact <= c_g | c_x;
            s1_tag     <= bus.in_tag;
        end
    end

    // NaN outranks Big, which outranks the post-rounding range check
    always_comb begin
        ovf = 1'b0;
        sat = '0;
        if (s1_nan) begin
            ovf = 1'b1;
            sat = s1_signed ? INT_MAX_S : INT_MAX_U;
        end else if (s1_signed) begin
            if (s1_sign) begin
                ovf = s1_big || (s1_mag > {1'b0, INT_MIN_S});
                sat = INT_MIN_S;
            end else begin
                ovf = s1_big || (s1_mag > {1'b0, INT_MAX_S});
                sat = INT_MAX_S;
            end
        end else begin
            if (s1_sign) begin
                ovf = s1_big || (s1_mag != '0);
                sat = '0;
            end else begin
                ovf = s1_big || s1_mag[32];
                sat = INT_MAX_U;
            end
        end
        r_result   = ovf ? sat : (s1_sign ? (~s1_mag[31:0] + 32'd1) : s1_mag[31:0]);
        r_flags    = '0;
        r_flags.nv = ovf;
        r_flags.nx = !ovf && s1_inexact;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
            s2_tag    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= r_result;
                s2_flags  <= r_flags;
                s2_tag    <= s1_tag;
            end
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;
    assign bus.out_fflags = s2_flags;
    assign bus.out_tag    = s2_tag;

endmodule

// File: tb/tb_fpu_f2i_round.sv
// Self-checking bench for fpu_f2i_round: directed conversions, stalls, flush and random traffic via a scoreboard.
module tb_fpu_f2i_round;

    localparam int TAG_W = 6;

    typedef struct {
        logic [31:0]      res;
        logic [4:0]       flg;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0] flt;
        logic        sg;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    logic clock;
    logic reset;
    logic flush;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];
    logic [31:0]      drv_res;
    logic [4:0]       drv_flg;
    logic [TAG_W-1:0] next_tag = '0;
    logic             rand_done;

    logic             prev_stall = 1'b0;
    logic             prev_flush = 1'b0;
    logic [31:0]      prev_result;
    logic [4:0]       prev_fflags;
    logic [TAG_W-1:0] prev_tag;

    fpu_f2i_round_if #(.TAG_W(TAG_W)) bus ();

    fpu_f2i_round #(.TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bench-side float-to-fixed shifter; out-of-range exponents return garbage the DUT must ignore
    function automatic logic [34:0] shifter(input logic [31:0] f);
        int           e;
        logic [127:0] w;
        e = int'(f[30:23]);
        if (e < 124 || e >= 159) return 35'h2_A5A5_A5A5;
        w = {104'b0, 1'b1, f[22:0]} << (e - 86);
        return {w[95:64], w[63], w[62], |w[61:0]};
    endfunction

    function automatic logic [36:0] model(input logic [31:0] f, input logic sg, input logic [2:0] rm);
        int          e;
        logic        s, g, x, up, inexact, nv;
        logic [1:0]  cls;
        logic [31:0] ip, res;
        logic [34:0] fx;
        longint      m, v;
        e = int'(f[30:23]);
        s = f[31];
        inexact = 1'b0;
        if (e == 255 && f[22:0] != 0) return {(sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF), 5'b10000};
        if (e >= 159) begin
            v = s ? -(64'sd1 <<< 40) : (64'sd1 <<< 40);
        end else begin
            if (f[30:0] == 0) begin
                ip = 0; g = 0; x = 0;
            end else if (e < 124) begin
                ip = 0; g = 0; x = 1;
            end else begin
                fx = shifter(f);
                ip = fx[34:3]; g = fx[2]; x = fx[1] | fx[0];
            end
            cls = {g, x};
            case (rm)
                3'd0:    up = (cls == 2'b11) || (cls == 2'b10 && ip[0]);
                3'd2:    up = s && (cls != 2'b00);
                3'd3:    up = !s && (cls != 2'b00);
                3'd4:    up = cls[1];
                default: up = 1'b0;
            endcase
            inexact = (cls != 2'b00);
            m = 0;
            m[31:0] = ip;
            m = m + (up ? 64'sd1 : 64'sd0);
            v = s ? -m : m;
        end
        nv = 1'b0;
        if (sg) begin
            if (v > 64'sd2147483647)       begin res = 32'h7FFF_FFFF; nv = 1; end
            else if (v < -64'sd2147483648) begin res = 32'h8000_0000; nv = 1; end
            else res = v[31:0];
        end else begin
            if (v < 0)                     begin res = 32'h0000_0000; nv = 1; end
            else if (v > 64'sd4294967295)  begin res = 32'hFFFF_FFFF; nv = 1; end
            else res = v[31:0];
        end
        return {res, (nv ? 5'b10000 : (inexact ? 5'b00001 : 5'b00000))};
    endfunction

    // Scoreboard: pop/compare on output transfer, clear on flush, push on input transfer
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (prev_stall && !prev_flush) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_result !== prev_result ||
                    bus.out_fflags !== prev_fflags || bus.out_tag !== prev_tag) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b res=%h flags=%b tag=%0d, need res=%h flags=%b tag=%0d",
                             bus.out_valid, bus.out_result, bus.out_fflags, bus.out_tag,
                             prev_result, prev_fflags, prev_tag);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got res=%h flags=%b tag=%0d with nothing outstanding",
                             bus.out_result, bus.out_fflags, bus.out_tag);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_result !== e.res || bus.out_fflags !== e.flg || bus.out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL result: got res=%h flags=%b tag=%0d, need res=%h flags=%b tag=%0d",
                                 bus.out_result, bus.out_fflags, bus.out_tag, e.res, e.flg, e.tag);
                    end
                end
            end
            if (flush) sb.delete();
            else if (bus.in_valid && bus.in_ready) sb.push_back('{res: drv_res, flg: drv_flg, tag: bus.in_tag});
        end
        prev_stall  = !reset && bus.out_valid && !bus.out_ready;
        prev_flush  = flush || reset;
        prev_result = bus.out_result;
        prev_fflags = bus.out_fflags;
        prev_tag    = bus.out_tag;
    end

    task automatic send(input logic [31:0] f, input logic sg, input logic [2:0] rm,
                        input logic [31:0] er, input logic [4:0] ef);
        int cyc = 0;
        bus.in_valid     = 1'b1;
        bus.in_flt       = f;
        bus.in_fixed     = shifter(f);
        bus.in_is_signed = sg;
        bus.in_rm        = rm;
        bus.in_tag       = next_tag;
        drv_res          = er;
        drv_flg          = ef;
        @(negedge clock);
        while (bus.in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 50) begin
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %b, need 1 within 50 cycles", bus.in_ready);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        next_tag     = next_tag + 1'b1;
    endtask

    task automatic drain(output logic ok);
        int cyc = 0;
        while ((sb.size() != 0 || bus.out_valid === 1'b1) && cyc < 200) begin
            @(posedge clock);
            cyc++;
        end
        repeat (3) @(posedge clock);
        #1;
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_flt       = '0;
        bus.in_fixed     = '0;
        bus.in_is_signed = 1'b0;
        bus.in_rm        = 3'd0;
        bus.in_tag       = '0;
        bus.out_ready    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'h0 ||
            bus.out_fflags !== 5'h0 || bus.out_tag !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b res=%h flags=%b tag=%0d, need 0 1 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out_result, bus.out_fflags, bus.out_tag);
        end
    endtask

    task automatic test_directed();
        vec_t vt[$];
        logic ok;
        vt = '{
            '{32'h3FC0_0000, 1'b1, 3'd0, 32'h0000_0002, 5'b00001},
            '{32'h4020_0000, 1'b1, 3'd0, 32'h0000_0002, 5'b00001},
            '{32'h4020_0000, 1'b1, 3'd4, 32'h0000_0003, 5'b00001},
            '{32'hC020_0000, 1'b1, 3'd2, 32'hFFFF_FFFD, 5'b00001},
            '{32'hC020_0000, 1'b1, 3'd1, 32'hFFFF_FFFE, 5'b00001},
            '{32'h4F32_D05E, 1'b0, 3'd0, 32'hB2D0_5E00, 5'b00000},
            '{32'h4F32_D05E, 1'b1, 3'd0, 32'h7FFF_FFFF, 5'b10000},
            '{32'h7FC0_0000, 1'b1, 3'd0, 32'h7FFF_FFFF, 5'b10000},
            '{32'h7FC0_0000, 1'b0, 3'd0, 32'hFFFF_FFFF, 5'b10000},
            '{32'hFF80_0000, 1'b1, 3'd0, 32'h8000_0000, 5'b10000},
            '{32'hBE99_999A, 1'b0, 3'd1, 32'h0000_0000, 5'b00001},
            '{32'hBE99_999A, 1'b0, 3'd2, 32'h0000_0000, 5'b10000},
            '{32'hCF00_0000, 1'b1, 3'd1, 32'h8000_0000, 5'b00000},
            '{32'h4F00_0000, 1'b1, 3'd1, 32'h7FFF_FFFF, 5'b10000},
            '{32'h4F7F_FFFF, 1'b0, 3'd0, 32'hFFFF_FF00, 5'b00000},
            '{32'h8000_0000, 1'b0, 3'd2, 32'h0000_0000, 5'b00000},
            '{32'h4020_0000, 1'b1, 3'd5, 32'h0000_0002, 5'b00001},
            '{32'hBF00_0000, 1'b0, 3'd0, 32'h0000_0000, 5'b00001},
            '{32'hBF80_0000, 1'b0, 3'd0, 32'h0000_0000, 5'b10000},
            '{32'h3D00_0000, 1'b1, 3'd3, 32'h0000_0001, 5'b00001},
            '{32'h3D00_0000, 1'b0, 3'd2, 32'h0000_0000, 5'b00001},
            '{32'h7F80_0000, 1'b0, 3'd0, 32'hFFFF_FFFF, 5'b10000}
        };
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        foreach (vt[i]) send(vt[i].flt, vt[i].sg, vt[i].rm, vt[i].res, vt[i].flg);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL directed_drain: %0d results outstanding, need 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        @(posedge clock);
        #1;
        next_tag      = '0;
        bus.out_ready = 1'b0;
        fork
            begin
                send(32'h3FC0_0000, 1'b1, 3'd0, 32'h0000_0002, 5'b00001);
                send(32'h4020_0000, 1'b1, 3'd4, 32'h0000_0003, 5'b00001);
                send(32'hC020_0000, 1'b1, 3'd1, 32'hFFFF_FFFE, 5'b00001);
                send(32'h4F32_D05E, 1'b0, 3'd0, 32'hB2D0_5E00, 5'b00000);
            end
            begin
                repeat (3) @(negedge clock);
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_backpressure: got in_ready=%b out_valid=%b, need 0 1",
                             bus.in_ready, bus.out_valid);
                end
                @(posedge clock);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_drain: %0d results outstanding, need 0", sb.size());
        end
    endtask

    task automatic test_flush();
        logic ok;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        fork
            begin
                send(32'h4020_0000, 1'b1, 3'd4, 32'h0000_0003, 5'b00001);
                send(32'hC020_0000, 1'b1, 3'd2, 32'hFFFF_FFFD, 5'b00001);
                send(32'h4F32_D05E, 1'b1, 3'd0, 32'h7FFF_FFFF, 5'b10000);
                send(32'h3FC0_0000, 1'b1, 3'd0, 32'h0000_0002, 5'b00001);
            end
            begin
                repeat (2) @(posedge clock);
                #1;
                flush = 1'b1;
                @(posedge clock);
                #1;
                flush = 1'b0;
                @(negedge clock);
                checks++;
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'h0 ||
                    bus.out_fflags !== 5'h0 || bus.out_tag !== '0) begin
                    errors++;
                    $display("FAIL flush_clear: got valid=%b ready=%b res=%h flags=%b tag=%0d, need 0 1 0 0 0",
                             bus.out_valid, bus.in_ready, bus.out_result, bus.out_fflags, bus.out_tag);
                end
            end
        join
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL flush_drain: %0d results outstanding, need 0", sb.size());
        end
    endtask

    task automatic test_random();
        logic ok;
        @(posedge clock);
        #1;
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [31:0] f;
                    logic [7:0]  e;
                    logic        sg;
                    logic [2:0]  rm;
                    logic [36:0] m;
                    case ($urandom_range(0, 5))
                        0:       e = 8'($urandom_range(120, 135));
                        1:       e = 8'($urandom_range(150, 162));
                        2:       e = 8'hFF;
                        3:       e = 8'($urandom_range(0, 123));
                        default: e = 8'($urandom_range(124, 158));
                    endcase
                    f = {1'($urandom_range(0, 1)), e, 23'($urandom)};
                    if ($urandom_range(0, 7) == 0) f[22:0] = '0;
                    sg = 1'($urandom_range(0, 1));
                    rm = 3'($urandom_range(0, 7));
                    m  = model(f, sg, rm);
                    send(f, sg, rm, m[36:5], m[4:0]);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL random_drain: %0d results outstanding, need 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
